// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_top transmit channel between NUM_REQ byte producers.
// Optional packet lock (keep the channel until req_last) is enabled with `define ARB_PACKET_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, PRESENT, DRAIN} state_t;

  state_t                  state, state_n;
  logic                    sync1, rdy_s;
  logic [IDX_W-1:0]        last_grant, last_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [DATA_WIDTH-1:0]   tx_data_n;
  logic                    tx_valid_n, timeout_n;
  logic [NUM_REQ-1:0]      grant_n, win_onehot;
  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;

`ifdef ARB_PACKET_LOCK_EN
  logic lock_active, lock_n;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  // tx_ready lives in the baud domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      sync1 <= tx_ready;
      rdy_s <= sync1;
    end
  end

  // Rotating-priority search starting just after the last owner
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!win_found && req_valid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
`ifdef ARB_PACKET_LOCK_EN
    // A locked packet owner is always the last granted requester
    if (lock_active) begin
      win_found = req_valid[last_grant];
      win_idx   = last_grant;
    end
`endif
  end

  assign win_onehot = NUM_REQ'(1) << win_idx;
  assign req_ready  = (state == IDLE && rdy_s && win_found) ? win_onehot : '0;

  always_comb begin
    state_n    = state;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    grant_n    = grant;
    last_n     = last_grant;
    cnt_n      = cnt;
    timeout_n  = 1'b0;
`ifdef ARB_PACKET_LOCK_EN
    lock_n     = lock_active;
`endif
    case (state)
      IDLE: begin
        if (rdy_s && win_found) begin
          state_n    = PRESENT;
          tx_data_n  = req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          tx_valid_n = 1'b1;
          grant_n    = win_onehot;
          last_n     = win_idx;
          cnt_n      = '0;
`ifdef ARB_PACKET_LOCK_EN
          lock_n     = !req_last[win_idx];
`endif
        end
      end
      PRESENT: begin
        cnt_n = cnt + 1'b1;
        // Acceptance takes precedence over a coincident timeout
        if (!rdy_s) begin
          tx_valid_n = 1'b0;
          state_n    = DRAIN;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tx_valid_n = 1'b0;
          grant_n    = '0;
          timeout_n  = 1'b1;
          state_n    = IDLE;
`ifdef ARB_PACKET_LOCK_EN
          lock_n     = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (rdy_s) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
`ifdef ARB_PACKET_LOCK_EN
      lock_active <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      grant       <= grant_n;
      busy        <= (state_n != IDLE);
      timeout_err <= timeout_n;
      last_grant  <= last_n;
      cnt         <= cnt_n;
`ifdef ARB_PACKET_LOCK_EN
      lock_active <= lock_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes are queued by the stimulus and a
// monitor pops one per tx_valid assertion. Lock-mode expectations follow ARB_PACKET_LOCK_EN.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NR-1:0] grant;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [NR-1:0]    grant;
  logic             busy;
  logic             timeout_err;

  logic uart_auto = 1'b0;
  logic man_rdy   = 1'b1;
  int   frame_ns  = 137;
  int   tests     = 0;
  int   failed    = 0;
  exp_t exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16), .CNT_W(12)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: manual level, or accept a presented byte and stay busy for one frame
  initial begin
    tx_ready = 1'b0;
    forever begin
      if (!uart_auto) begin
        tx_ready = man_rdy;
        #1;
      end else if (tx_valid && tx_ready) begin
        #7 tx_ready = 1'b0;
        #(frame_ns) tx_ready = 1'b1;
        #1;
      end else begin
        tx_ready = 1'b1;
        #3;
      end
    end
  end

  // Monitor: one scoreboard entry per rising tx_valid
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (tx_valid && !prev) begin
          tests++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_byte: got data=%0h grant=%b, expected nothing", tx_data, grant);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || grant !== e.grant) begin
              failed++;
              $display("FAIL byte: got data=%0h grant=%b, expected data=%0h grant=%b",
                       tx_data, grant, e.data, e.grant);
            end
          end
        end
        prev = tx_valid;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [NR-1:0] g);
    exp_q.push_back('{data: d, grant: g});
  endtask

  task automatic do_reset();
    uart_auto = 1'b0;
    man_rdy   = 1'b1;
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_after_drain", 32'(busy), 32'd0);
  endtask

  // Requester behaviour after each accepted byte
  task automatic update(input int scen, input logic [NR-1:0] w, input int sent, input int n);
    case (scen)
      2: req_data[15:8] = 8'(8'h40 + sent);
      3: begin
        if (w[2]) begin
          case (req_data[23:16])
            8'h21:   req_data[23:16] = 8'h22;
            8'h22:   begin req_data[23:16] = 8'h23; req_last[2] = 1'b1; end
            default: req_valid[2] = 1'b0;
          endcase
        end
        if (w[0]) req_data[7:0] = req_data[7:0] + 8'h01;
        req_valid[0] = 1'b1;
      end
      default: ;
    endcase
    if (sent == n) req_valid = '0;
  endtask

  task automatic run_xfers(input int n, input int scen);
    int sent, cyc;
    logic [NR-1:0] w;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      w = req_valid & req_ready;
      if (w != '0) begin
        @(posedge clk);
        #1;
        sent++;
        update(scen, w, sent, n);
      end
    end
    check("transfer_count", 32'(sent), 32'(n));
  endtask

  initial begin
    int hi, tcnt, n;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // Single byte: synchronizer delay, one-cycle latency, drop after tx_ready falls
    req_valid     = 4'b0001;
    req_data[7:0] = 8'hA5;
    push(8'hA5, 4'b0001);
    reset = 1'b0;
    @(posedge clk); #1 check("ready_after_1", 32'(req_ready), 32'd0);
    @(posedge clk); #1 check("ready_after_2", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    check("first_valid", 32'(tx_valid), 32'd1);
    check("first_grant", 32'(grant), 32'b0001);
    check("first_busy", 32'(busy), 32'd1);
    req_valid = '0;
    man_rdy   = 1'b0;
    @(posedge clk); #1 check("valid_hold_1", 32'(tx_valid), 32'd1);
    @(posedge clk); #1 check("valid_hold_2", 32'(tx_valid), 32'd1);
    @(posedge clk); #1;
    check("valid_dropped", 32'(tx_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_grant", 32'(grant), 32'b0001);
    man_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_grant", 32'(grant), 32'd0);

    // Fairness: all requesters valid, bytes rotate 0,1,2,3
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 4'(1 << i));
    req_valid = 4'b1111;
    uart_auto = 1'b1;
    run_xfers(12, 1);
    wait_drain();
    uart_auto = 1'b0;

    // Timeout: transmitter never accepts
    do_reset();
    req_data[7:0]  = 8'hA0;
    req_data[15:8] = 8'hB1;
    push(8'hA0, 4'b0001);
    push(8'hB1, 4'b0010);
    req_valid = 4'b0011;
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    hi   = 0;
    tcnt = 0;
    while (tx_valid && hi < 100) begin
      if (timeout_err) tcnt++;
      hi++;
      @(negedge clk);
    end
    check("timeout_valid_cycles", 32'(hi), 32'd16);
    check("no_early_timeout", 32'(tcnt), 32'd0);
    check("timeout_pulse", 32'(timeout_err), 32'd1);
    check("timeout_grant", 32'(grant), 32'd0);
    check("timeout_next_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("timeout_pulse_end", 32'(timeout_err), 32'd0);
    check("retry_other_grant", 32'(grant), 32'b0010);

    // Asynchronous reset mid-presentation, then restart from requester 0
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    push(8'hA0, 4'b0001);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!tx_valid && n < 10) begin @(negedge clk); n++; end
    check("restart_grant", 32'(grant), 32'b0001);
    #2 reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // 100 bytes from requester 1 against an asynchronous transmitter
    do_reset();
    req_data[15:8] = 8'h40;
    for (int k = 0; k < 100; k++) push(8'(8'h40 + k), 4'b0010);
    req_valid = 4'b0010;
    uart_auto = 1'b1;
    run_xfers(100, 2);
    wait_drain();
    uart_auto = 1'b0;

    // Three-byte packet from requester 2 with requester 0 competing
    do_reset();
    req_data[23:16] = 8'h21;
    req_data[7:0]   = 8'h01;
    req_valid       = 4'b0100;
`ifdef ARB_PACKET_LOCK_EN
    push(8'h21, 4'b0100);
    push(8'h22, 4'b0100);
    push(8'h23, 4'b0100);
    push(8'h01, 4'b0001);
    n = 4;
`else
    push(8'h21, 4'b0100);
    push(8'h01, 4'b0001);
    push(8'h22, 4'b0100);
    push(8'h02, 4'b0001);
    push(8'h23, 4'b0100);
    n = 5;
`endif
    uart_auto = 1'b1;
    run_xfers(n, 3);
    wait_drain();
    uart_auto = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
